// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a main register, a skid register and a registered in_ready.
// Latency 1 cycle; backpressure holds the payload, and in_ready drops only once both entries are occupied.
// Build option PIPE_STG_STATS_EN adds stall and bubble counters that saturate at their maximum.
module pipe_stage_skid #(
  parameter int DATA_W = 140,
  parameter int CNT_W  = 16
) (
  input  logic              stg_clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STG_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_BUSY;
          main_d  = in_data;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything held plus anything arriving this cycle; payload regs keep stale data.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef PIPE_STG_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (stats_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + 1'b1;
      end
      if (!out_valid_q && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_d = bubble_q + 1'b1;
      end
    end
  end

  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid with DATA_W=8, CNT_W=4.
module tb_pipe_stage_skid;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              stg_clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STG_STATS_EN
  logic              stats_clr;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 stg_clk = ~stg_clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .stg_clk   (stg_clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STG_STATS_EN
    ,
    .stats_clr (stats_clr),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge stg_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef PIPE_STG_STATS_EN
    stats_clr = 1'b0;
`endif
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      $display("FAIL reset_init: got v=%b r=%b d=%h expected v=0 r=1 d=00", out_valid, in_ready, out_data);
      errors++;
    end
    reset_n = 1'b1;
    step();
    // Load an entry, then yank reset mid-cycle.
    in_valid = 1'b1; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      $display("FAIL reset_preload: got v=%b d=%h expected v=1 d=55", out_valid, out_data);
      errors++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      $display("FAIL reset_async: got v=%b r=%b d=%h expected v=0 r=1 d=00", out_valid, in_ready, out_data);
      errors++;
    end
    #2 reset_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vec [3];
    vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vec[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vec[i] || in_ready !== 1'b1) begin
        $display("FAIL b2b_%0d: got v=%b d=%h r=%b expected v=1 d=%h r=1", i, out_valid, out_data, in_ready, vec[i]);
        errors++;
      end
    end
    in_valid = 1'b0; in_data = 'x;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL b2b_drain: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_skid_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A;
    step();
    in_data = 8'h0B;
    step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h0A) begin
      $display("FAIL skid_full: got v=%b r=%b d=%h expected v=1 r=0 d=0a", out_valid, in_ready, out_data);
      errors++;
    end
    in_data = 8'h0C;
    step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h0A) begin
      $display("FAIL skid_hold: got v=%b r=%b d=%h expected v=1 r=0 d=0a", out_valid, in_ready, out_data);
      errors++;
    end
    // 0A leaves on this edge; 0C still blocked because in_ready was low.
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 8'h0B) begin
      $display("FAIL skid_out_b: got v=%b r=%b d=%h expected v=1 r=1 d=0b", out_valid, in_ready, out_data);
      errors++;
    end
    step();
    in_valid = 1'b0; in_data = 'x;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0C) begin
      $display("FAIL skid_out_c: got v=%b d=%h expected v=1 d=0c", out_valid, out_data);
      errors++;
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL skid_empty: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A;
    step();
    in_data = 8'h0B;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL flush_prefull: got r=%b expected r=0", in_ready);
      errors++;
    end
    flush = 1'b1; in_data = 8'h0C;
    step();
    flush = 1'b0; in_valid = 1'b0; in_data = 'x;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_clear: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
      errors++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_no_c_%0d: got v=%b d=%h expected v=0", i, out_valid, out_data);
        errors++;
      end
    end
    // Flush from BUSY with accept on both sides: nothing should survive.
    in_valid = 1'b1; in_data = 8'h21;
    step();
    flush = 1'b1; in_data = 8'h22;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_busy: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] q[$];
    logic exp_rdy;
    int bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = in_valid ? DATA_W'($urandom) : 'x;
      exp_rdy   = (q.size() < 2);
      checks++;
      if (in_ready !== exp_rdy || out_valid !== (q.size() > 0) ||
          (q.size() > 0 && out_data !== q[0])) begin
        if (bad < 10)
          $display("FAIL random_cyc%0d: got v=%b r=%b d=%h expected v=%b r=%b d=%h", cyc,
                   out_valid, in_ready, out_data, (q.size() > 0), exp_rdy, (q.size() > 0) ? q[0] : 8'h00);
        bad++;
        errors++;
      end
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && exp_rdy) q.push_back(in_data);
      checks++;
      if (q.size() > 2) begin
        $display("FAIL random_depth: got depth %0d expected <= 2", q.size());
        errors++;
      end
      step();
    end
    in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL random_drain: got v=%b expected v=0", out_valid);
      errors++;
    end
  endtask

`ifdef PIPE_STG_STATS_EN
  task automatic test_stats();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77; stats_clr = 1'b1;
    step();
    stats_clr = 1'b0; in_valid = 1'b0; in_data = 'x;
    checks++;
    if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin
      $display("FAIL stats_clr0: got s=%h b=%h expected s=0 b=0", stall_cnt, bubble_cnt);
      errors++;
    end
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (stall_cnt !== 4'hF || bubble_cnt !== 4'h0) begin
      $display("FAIL stats_sat: got s=%h b=%h expected s=f b=0", stall_cnt, bubble_cnt);
      errors++;
    end
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    checks++;
    if (stall_cnt !== 4'h0) begin
      $display("FAIL stats_clr1: got s=%h expected s=0", stall_cnt);
      errors++;
    end
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bubble_cnt !== 4'h3 || stall_cnt !== 4'h0) begin
      $display("FAIL stats_bubble: got s=%h b=%h expected s=0 b=3", stall_cnt, bubble_cnt);
      errors++;
    end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_skid_backpressure();
    test_flush();
    test_random();
`ifdef PIPE_STG_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
